// File: rtl/record_player.sv
// Plays back a stored list of notes: fetches each record, holds it for its
// duration in ticks, inserts a silent gap, and pulses done at the end or on abort.
module record_player #(
    parameter int REC_CNT_BITS   = 5,
    parameter int OCTAVE_BITS    = 2,
    parameter int NOTE_BITS      = 4,
    parameter int LENGTH_BITS    = 3,
    parameter int FULL_NOTE_BITS = 4,
    parameter int GAP_TICKS      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick,
    input  logic                      start,
    input  logic                      stop,
    input  logic [REC_CNT_BITS:0]     num_notes,
    output logic [REC_CNT_BITS-1:0]   rd_cnt,
    input  logic [OCTAVE_BITS-1:0]    octave_r,
    input  logic [NOTE_BITS-1:0]      note_r,
    input  logic [LENGTH_BITS-1:0]    length_r,
    input  logic [FULL_NOTE_BITS-1:0] full_note_r,
    output logic [OCTAVE_BITS-1:0]    play_octave,
    output logic [NOTE_BITS-1:0]      play_note,
    output logic                      play_valid,
    output logic                      busy,
    output logic                      done
);

    // state | meaning
    // IDLE  | waiting for start
    // FETCH | one cycle: latch record fields and duration
    // PLAY  | note (or recorded rest) sounding, counting duration ticks
    // GAP   | silence after the note, counting GAP_TICKS ticks
    typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

    localparam logic [15:0] GAP_LOAD = 16'(GAP_TICKS);

    state_t                state;
    logic [REC_CNT_BITS:0] num_lat;
    logic [8:0]            dur_cnt;
    logic [15:0]           gap_cnt;
    logic [8:0]            dur_full;
    logic [8:0]            dur_raw;
    logic [8:0]            dur_next;
    logic                  last;
    logic                  advance;

    always_comb begin
        dur_full = (9'(full_note_r) + 9'd1) << 4;
        dur_raw  = dur_full >> length_r;
        dur_next = (dur_raw == 9'd0) ? 9'd1 : dur_raw;
    end

    assign last = (({1'b0, rd_cnt} + 1'b1) == num_lat);

    // End of a record: last gap tick, or last play tick when there is no gap.
    assign advance = tick && (((state == PLAY) && (dur_cnt == 9'd1) && (GAP_TICKS == 0)) ||
                              ((state == GAP) && (gap_cnt == 16'd1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_cnt      <= '0;
            num_lat     <= '0;
            dur_cnt     <= '0;
            gap_cnt     <= '0;
            play_octave <= '0;
            play_note   <= '0;
            play_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state != IDLE) && stop) begin
                state       <= IDLE;
                busy        <= 1'b0;
                play_valid  <= 1'b0;
                play_note   <= '0;
                play_octave <= '0;
                done        <= 1'b1;
            end else if (advance) begin
                play_valid <= 1'b0;
                play_note  <= '0;
                if (last) begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    play_octave <= '0;
                    done        <= 1'b1;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                    state  <= FETCH;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (num_notes != '0) begin
                                num_lat <= num_notes;
                                rd_cnt  <= '0;
                                busy    <= 1'b1;
                                state   <= FETCH;
                            end else if (!done) begin
                                // back-to-back empty requests must not stretch done
                                done <= 1'b1;
                            end
                        end
                    end
                    FETCH: begin
                        play_octave <= octave_r;
                        play_note   <= note_r;
                        play_valid  <= (note_r != '0);
                        dur_cnt     <= dur_next;
                        state       <= PLAY;
                    end
                    PLAY: begin
                        if (tick) begin
                            dur_cnt <= dur_cnt - 9'd1;
                            if (dur_cnt == 9'd1) begin
                                state      <= GAP;
                                gap_cnt    <= GAP_LOAD;
                                play_valid <= 1'b0;
                                play_note  <= '0;
                            end
                        end
                    end
                    GAP: begin
                        if (tick) gap_cnt <= gap_cnt - 16'd1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_record_player.sv
// Self-checking bench for record_player: per-record scoreboard of durations and
// notes, plus hand sequences for empty start, stop, and async reset.
module tb_record_player;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [5:0] num_notes = '0;
    logic [4:0] rd_cnt;
    logic [1:0] octave_r;
    logic [3:0] note_r;
    logic [2:0] length_r;
    logic [3:0] full_note_r;
    logic [1:0] play_octave;
    logic [3:0] play_note;
    logic       play_valid;
    logic       busy;
    logic       done;

    logic [1:0] m_oct  [32];
    logic [3:0] m_note [32];
    logic [2:0] m_len  [32];
    logic [3:0] m_fn   [32];

    assign octave_r    = m_oct[rd_cnt];
    assign note_r      = m_note[rd_cnt];
    assign length_r    = m_len[rd_cnt];
    assign full_note_r = m_fn[rd_cnt];

    record_player #(.GAP_TICKS(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop),
        .num_notes(num_notes), .rd_cnt(rd_cnt), .octave_r(octave_r), .note_r(note_r),
        .length_r(length_r), .full_note_r(full_note_r), .play_octave(play_octave),
        .play_note(play_note), .play_valid(play_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int oct; int note; int len; int fn; int dur;
    } vec_t;

    typedef struct {
        int idx; int oct; int note; int vt; int tt;
    } exp_t;

    vec_t vec [8];
    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   mon_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor: one segment per rd_cnt value while busy
    int  cur = -1;
    int  vt, tt, cap_note, cap_oct;
    bit  cap;
    bit  prev_done = 0;

    task automatic close_seg();
        exp_t e;
        chk("sb_has_entry", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rec_idx", cur, e.idx);
            chk("rec_valid_ticks", vt, e.vt);
            chk("rec_total_ticks", tt, e.tt);
            chk("rec_note", cap_note, e.note);
            if (e.note != 0) chk("rec_octave", cap_oct, e.oct);
        end
        cur = -1;
    endtask

    always @(negedge clk) begin
        if (done) chk("done_single_cycle", int'(prev_done), 0);
        prev_done = done;
        if (!mon_en) begin
            cur = -1;
        end else begin
            if (cur >= 0 && (!busy || int'(rd_cnt) != cur)) close_seg();
            if (busy && cur < 0) begin
                cur = int'(rd_cnt); vt = 0; tt = 0; cap = 0; cap_note = 0; cap_oct = 0;
            end
            if (busy) begin
                if (tick) tt++;
                if (tick && play_valid) vt++;
                if (play_valid && !cap) begin
                    cap = 1; cap_note = int'(play_note); cap_oct = int'(play_octave);
                end
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tick  = (cyc % 4 == 0);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic start_play();
        int n = 0;
        while (!tick && n < 8) begin step(); n++; end
        start = 1'b1;
        step();
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && n < limit) begin step(); n++; end
        chk("done_within_budget", int'(done), 1);
    endtask

    task automatic load(input int slot, input vec_t v);
        m_oct[slot]  = 2'(v.oct);
        m_note[slot] = 4'(v.note);
        m_len[slot]  = 3'(v.len);
        m_fn[slot]   = 4'(v.fn);
    endtask

    task automatic push_exp(input int slot, input vec_t v);
        exp_t e;
        e.idx = slot; e.oct = v.oct; e.note = v.note;
        e.vt = (v.note != 0) ? v.dur : 0;
        e.tt = v.dur + GAP;
        sb.push_back(e);
    endtask

    initial begin
        int r;
        vec[0] = '{1, 5, 2, 3, 16};
        vec[1] = '{2, 7, 0, 0, 16};
        vec[2] = '{0, 1, 4, 0, 1};
        vec[3] = '{3, 9, 0, 15, 256};
        vec[4] = '{1, 2, 7, 15, 2};
        vec[5] = '{2, 4, 7, 0, 1};
        vec[6] = '{0, 0, 1, 1, 16};
        vec[7] = '{3, 15, 3, 7, 16};
        for (int i = 0; i < 32; i++) load(i, vec[0]);

        // reset state
        step(); step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd_cnt", int'(rd_cnt), 0);
        chk("rst_play_valid", int'(play_valid), 0);
        chk("rst_play_note", int'(play_note), 0);
        chk("rst_play_octave", int'(play_octave), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;
        step();

        // empty playback request
        num_notes = 6'd0;
        start = 1'b1;
        step();
        chk("empty_done", int'(done), 1);
        chk("empty_busy", int'(busy), 0);
        chk("empty_rd_cnt", int'(rd_cnt), 0);
        step();
        chk("empty_done_clear", int'(done), 0);

        // stop while idle
        stop = 1'b1;
        step();
        chk("idle_stop_done", int'(done), 0);
        chk("idle_stop_busy", int'(busy), 0);

        // single-record vectors
        mon_en = 1;
        for (int i = 0; i < 8; i++) begin
            load(0, vec[i]);
            num_notes = 6'd1;
            push_exp(0, vec[i]);
            start_play();
            wait_done(2000);
            step();
            chk("sb_drained_vec", sb.size(), 0);
        end

        // three-record list; num_notes changes after start must be ignored
        for (int i = 0; i < 3; i++) begin load(i, vec[i]); push_exp(i, vec[i]); end
        num_notes = 6'd3;
        start_play();
        num_notes = 6'd1;
        wait_done(2000);
        chk("list3_last_rd_cnt", int'(rd_cnt), 2);
        step();
        chk("sb_drained_list3", sb.size(), 0);

        // full 32-entry list: no wrap after entry 31
        for (int i = 0; i < 32; i++) begin load(i, vec[i % 8]); push_exp(i, vec[i % 8]); end
        num_notes = 6'd32;
        start_play();
        wait_done(20000);
        chk("list32_last_rd_cnt", int'(rd_cnt), 31);
        repeat (3) step();
        chk("sb_drained_list32", sb.size(), 0);
        chk("list32_idle", int'(busy), 0);

        // stop coincident with tick mid-note; start while busy ignored
        mon_en = 0;
        sb.delete();
        load(0, vec[3]);
        load(1, vec[3]);
        num_notes = 6'd2;
        start_play();
        repeat (10) step();
        num_notes = 6'd0;
        start = 1'b1;
        step();
        chk("busy_start_no_done", int'(done), 0);
        chk("busy_start_still_busy", int'(busy), 1);
        r = 0;
        while (!(tick && play_valid) && r < 16) begin step(); r++; end
        chk("stop_setup_playing", int'(play_valid), 1);
        r = int'(rd_cnt);
        stop = 1'b1;
        step();
        chk("stop_busy", int'(busy), 0);
        chk("stop_play_valid", int'(play_valid), 0);
        chk("stop_play_note", int'(play_note), 0);
        chk("stop_done", int'(done), 1);
        chk("stop_rd_cnt", int'(rd_cnt), r);
        step();
        chk("stop_done_once", int'(done), 0);

        // async reset mid-note during entry 1
        load(0, vec[2]);
        load(1, vec[3]);
        num_notes = 6'd2;
        start_play();
        r = 0;
        while (!(rd_cnt == 5'd1 && play_valid) && r < 200) begin step(); r++; end
        chk("rst_setup_entry1", int'(rd_cnt), 1);
        repeat (6) step();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_play_valid", int'(play_valid), 0);
        chk("arst_play_note", int'(play_note), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_rd_cnt", int'(rd_cnt), 0);
        chk("arst_done", int'(done), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_no_done", int'(done), 0);
        step();

        // playback after reset begins at entry 0
        mon_en = 1;
        num_notes = 6'd1;
        push_exp(0, vec[2]);
        start_play();
        wait_done(500);
        step();
        chk("sb_drained_post_rst", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/record_player.md
RECORD_PLAYER -- requirements
Module: record_player

Interface
REQ-001 SHALL have parameter REC_CNT_BITS, default 5: record address width, capacity 32 entries.
REQ-002 SHALL have parameter OCTAVE_BITS, default 2; NOTE_BITS, default 4; LENGTH_BITS, default 3; FULL_NOTE_BITS, default 4: field widths identical to the record store.
REQ-003 SHALL have parameter GAP_TICKS, default 2: silent ticks inserted after each note.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have ports, one per line:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- tick  in  1  one-cycle timebase strobe
- start  in  1  one-cycle playback request
- stop  in  1  one-cycle abort request
- num_notes  in  REC_CNT_BITS+1  entries to play, 0..32
- rd_cnt  out  REC_CNT_BITS  record read address, drives the store's cnt; store rw held 0 by the integrator
- octave_r, note_r, length_r, full_note_r  in  field widths  combinational read data at rd_cnt
- play_octave  out  OCTAVE_BITS  current octave
- play_note  out  NOTE_BITS  current note, 0 = rest/silence
- play_valid  out  1  high while a note sounds
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on completion or abort

Function
REQ-006 SHALL implement FSM states IDLE, FETCH, PLAY, GAP.
REQ-007 IDLE: start=1 with num_notes>0 SHALL go to FETCH with rd_cnt=0; start with num_notes=0 SHALL pulse done next cycle and stay IDLE.
REQ-008 SHALL ignore start while busy.
REQ-009 FETCH lasts exactly one cycle: latch octave_r, note_r and dur into registers; go to PLAY.
REQ-010 dur SHALL be ((full_note_r+1) << 4) >> length_r, computed in 9 bits; result 0 SHALL be forced to 1.
REQ-011 PLAY: play_valid=1, play_octave/play_note = latched values; each tick decrements the duration counter; on the tick that makes it 0, go to GAP.
REQ-012 A latched note of 0 in PLAY SHALL keep play_valid=0 for its full duration (recorded rest).
REQ-013 GAP: play_valid=0, play_note=0; count GAP_TICKS ticks; GAP_TICKS=0 SHALL skip GAP, taking the next transition directly from PLAY.
REQ-014 Leaving GAP (or PLAY when GAP_TICKS=0): if rd_cnt+1 == num_notes, pulse done and go to IDLE; else increment rd_cnt and go to FETCH.
REQ-015 rd_cnt SHALL wrap from 31 to 0 only if num_notes=32 is not yet reached; num_notes>32 is impossible by width limit.
REQ-016 stop=1 in any non-IDLE state SHALL go to IDLE next cycle, clear play_valid and play_note, and pulse done; stop has priority over tick in the same cycle.
REQ-017 stop in IDLE SHALL have no effect and not pulse done.
REQ-018 num_notes SHALL be sampled at start; later changes are ignored until the next start.
REQ-019 done SHALL never be high for two consecutive cycles.

Reset
REQ-020 rst_n=0 SHALL asynchronously force state IDLE, rd_cnt=0, play_octave=0, play_note=0, play_valid=0, busy=0, done=0 and clear all counters.
REQ-021 Reset during PLAY SHALL abort without a done pulse; after release, the first start begins at rd_cnt=0.

Verification
REQ-022 Entries 0..2 = {oct1,n5,len2,fn3},{oct2,n7,len0,fn0},{oct0,n1,len4,fn0}, num_notes=3, start -> note durations 16,16,1 ticks, each followed by 2 gap ticks, rd_cnt 0,1,2, single done pulse.
REQ-023 start with num_notes=0 -> done pulses next cycle, busy stays 0, rd_cnt stays 0.
REQ-024 stop asserted coincident with tick mid-PLAY -> next cycle IDLE, play_valid=0, done=1 once, no rd_cnt increment.
REQ-025 Entry with note=0, fn=1, len=1 -> 16 ticks with play_valid=0, then normal advance.
REQ-026 num_notes=32 -> rd_cnt steps 0..31, done after the entry at 31, no wrap to 0 while playing.
REQ-027 rst_n pulled low asynchronously mid-note (between clock edges) -> outputs zero immediately, no done; subsequent start plays from entry 0.
